// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the memory-controller command path.
// The count helper slices one queue's occupancy out of a packed count bus.
package mem_ctrl_pkg;

  localparam int CMD_W        = 72;
  localparam int MEMC_NUM_Q   = 4;
  localparam int MEMC_Q_DEPTH = 16;
  localparam int MEMC_CW      = $clog2(MEMC_Q_DEPTH) + 1;

  typedef enum logic {
    LK_IDLE = 1'b0,
    LK_HELD = 1'b1
  } lock_state_e;

  function automatic logic [MEMC_CW-1:0] count_slice(
    input logic [MEMC_NUM_Q*MEMC_CW-1:0] cnt,
    input int unsigned                   q
  );
    return cnt[q*MEMC_CW +: MEMC_CW];
  endfunction

endpackage

// File: rtl/mem_ctrl_rr_arb.sv
// Rotating-priority arbiter with an urgent subset and a grant lock.
// Purely combinational; the caller owns the pointer and lock registers.
module mem_ctrl_rr_arb #(
  parameter int NUM_Q = 4,
  parameter int QW    = $clog2(NUM_Q)
) (
  input  logic [NUM_Q-1:0] req_i,
  input  logic [NUM_Q-1:0] urgent_i,
  input  logic [QW-1:0]    ptr_i,
  input  logic             lock_i,
  input  logic [QW-1:0]    lock_idx_i,
  output logic             gnt_valid_o,
  output logic [QW-1:0]    gnt_idx_o
);

  logic [NUM_Q-1:0] hot;
  logic [NUM_Q-1:0] elig;
  logic [QW-1:0]    idx;

  always_comb begin
    hot         = req_i & urgent_i;
    elig        = (|hot) ? hot : req_i;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    if (lock_i) begin
      gnt_valid_o = req_i[lock_idx_i];
      gnt_idx_o   = lock_idx_i;
    end else begin
      // Scan from the farthest offset down so the nearest hit to ptr_i wins.
      for (int i = NUM_Q - 1; i >= 0; i--) begin
        idx = ptr_i + QW'(i);
        if (elig[idx]) begin
          gnt_valid_o = 1'b1;
          gnt_idx_o   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_cmd_vq.sv
// Multi-queue command buffer: NUM_Q FIFOs in one partitioned array, one shared
// pop port. Handshake: a transfer happens on a cycle where valid && ready.
module mem_ctrl_cmd_vq
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH    = CMD_W,
  parameter int DEPTH    = MEMC_Q_DEPTH,
  parameter int NUM_Q    = MEMC_NUM_Q,
  parameter int AFULL_TH = 12,
  parameter int QW       = $clog2(NUM_Q),
  parameter int CW       = $clog2(DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_valid_i,
  input  logic [QW-1:0]       wr_qid_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  output logic                wr_ready_o,
  output logic                rd_valid_o,
  output logic [WIDTH-1:0]    rd_data_o,
  output logic [QW-1:0]       rd_qid_o,
  input  logic                rd_ready_i,
  input  logic [NUM_Q-1:0]    urgent_i,
  input  logic [NUM_Q-1:0]    flush_i,
  output logic [NUM_Q-1:0]    empty_o,
  output logic [NUM_Q-1:0]    full_o,
  output logic [NUM_Q-1:0]    afull_o,
  output logic [NUM_Q*CW-1:0] count_o
);

  localparam int AW = QW + CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [WIDTH-1:0] mem_q [NUM_Q*DEPTH];

  logic [CW-1:0]    wr_ptr_q [NUM_Q];
  logic [CW-1:0]    wr_ptr_d [NUM_Q];
  logic [CW-1:0]    rd_ptr_q [NUM_Q];
  logic [CW-1:0]    rd_ptr_d [NUM_Q];
  logic [CW-1:0]    count_q  [NUM_Q];
  logic [CW-1:0]    count_d  [NUM_Q];
  logic [NUM_Q-1:0] empty_q, empty_d;
  logic [NUM_Q-1:0] full_q, full_d;
  logic [NUM_Q-1:0] afull_q, afull_d;

  lock_state_e      lock_state_q, lock_state_d;
  logic [QW-1:0]    lock_qid_q, lock_qid_d;
  logic [QW-1:0]    rr_ptr_q, rr_ptr_d;

  logic             gnt_valid;
  logic [QW-1:0]    gnt_qid;
  logic             push;
  logic             pop;
  logic [NUM_Q-1:0] push_vec;
  logic [NUM_Q-1:0] pop_vec;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  mem_ctrl_rr_arb #(
    .NUM_Q (NUM_Q),
    .QW    (QW)
  ) u_arb (
    .req_i       (~empty_q),
    .urgent_i    (urgent_i),
    .ptr_i       (rr_ptr_q),
    .lock_i      (lock_state_q == LK_HELD),
    .lock_idx_i  (lock_qid_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_qid)
  );

  // Full is the registered flag, so a push to a full queue is refused even
  // when the same queue pops this cycle.
  assign wr_ready_o = !full_q[wr_qid_i] && !flush_i[wr_qid_i];
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_valid_o && rd_ready_i && !flush_i[rd_qid_o];
  assign wr_addr    = {wr_qid_i, wr_ptr_q[wr_qid_i][CW-2:0]};
  assign rd_addr    = {gnt_qid, rd_ptr_q[gnt_qid][CW-2:0]};

  // Output process: grant and head word straight from registered state.
  always_comb begin
    rd_valid_o = gnt_valid;
    rd_qid_o   = gnt_qid;
    rd_data_o  = '0;
    if (gnt_valid) begin
      rd_data_o = mem_q[rd_addr];
    end
  end

  // Next-state process for the grant lock and round-robin pointer.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_qid_d   = lock_qid_q;
    rr_ptr_d     = rr_ptr_q;
    if (pop) begin
      lock_state_d = LK_IDLE;
      rr_ptr_d     = rd_qid_o + QW'(1);
    end else if (rd_valid_o && !flush_i[rd_qid_o]) begin
      lock_state_d = LK_HELD;
      lock_qid_d   = rd_qid_o;
    end else begin
      lock_state_d = LK_IDLE;
    end
  end

  // State register process.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_state_q <= LK_IDLE;
      lock_qid_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_qid_q   <= lock_qid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      push_vec[q] = push && (wr_qid_i == QW'(q));
      pop_vec[q]  = pop && (rd_qid_o == QW'(q));
      wr_ptr_d[q] = wr_ptr_q[q] + CW'(push_vec[q]);
      rd_ptr_d[q] = rd_ptr_q[q] + CW'(pop_vec[q]);
      count_d[q]  = count_q[q] + CW'(push_vec[q]) - CW'(pop_vec[q]);
      // Flush wins over any push or pop aimed at the same queue.
      if (flush_i[q]) begin
        wr_ptr_d[q] = '0;
        rd_ptr_d[q] = '0;
        count_d[q]  = '0;
      end
      empty_d[q] = (count_d[q] == '0);
      full_d[q]  = (count_d[q] == DEPTH_C);
      afull_d[q] = (count_d[q] >= AFULL_C);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int q = 0; q < NUM_Q; q++) begin
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        count_q[q]  <= '0;
      end
      empty_q <= '1;
      full_q  <= '0;
      afull_q <= '0;
    end else begin
      for (int q = 0; q < NUM_Q; q++) begin
        wr_ptr_q[q] <= wr_ptr_d[q];
        rd_ptr_q[q] <= rd_ptr_d[q];
        count_q[q]  <= count_d[q];
      end
      empty_q <= empty_d;
      full_q  <= full_d;
      afull_q <= afull_d;
    end
  end

  // Storage is deliberately not reset; stale words are hidden by the counts.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_addr] <= wr_data_i;
    end
  end

  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      count_o[q*CW +: CW] = count_q[q];
    end
  end

  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign afull_o = afull_q;

endmodule

// File: tb/tb_mem_ctrl_cmd_vq.sv
// Bench for mem_ctrl_cmd_vq: a hand-computed vector table, directed corner
// sequences, and random traffic compared with a queue-based reference model.
module tb_mem_ctrl_cmd_vq;
  import mem_ctrl_pkg::*;

  localparam int WIDTH    = 72;
  localparam int DEPTH    = 16;
  localparam int NUM_Q    = 4;
  localparam int AFULL_TH = 12;
  localparam int QW       = 2;
  localparam int CW       = 5;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                wr_valid_i;
  logic [QW-1:0]       wr_qid_i;
  logic [WIDTH-1:0]    wr_data_i;
  logic                wr_ready_o;
  logic                rd_valid_o;
  logic [WIDTH-1:0]    rd_data_o;
  logic [QW-1:0]       rd_qid_o;
  logic                rd_ready_i;
  logic [NUM_Q-1:0]    urgent_i;
  logic [NUM_Q-1:0]    flush_i;
  logic [NUM_Q-1:0]    empty_o;
  logic [NUM_Q-1:0]    full_o;
  logic [NUM_Q-1:0]    afull_o;
  logic [NUM_Q*CW-1:0] count_o;

  mem_ctrl_cmd_vq #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .NUM_Q    (NUM_Q),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_valid_i (wr_valid_i),
    .wr_qid_i   (wr_qid_i),
    .wr_data_i  (wr_data_i),
    .wr_ready_o (wr_ready_o),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .rd_qid_o   (rd_qid_o),
    .rd_ready_i (rd_ready_i),
    .urgent_i   (urgent_i),
    .flush_i    (flush_i),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .afull_o    (afull_o),
    .count_o    (count_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  // Reference model: one plain queue per hardware queue plus arbitration memory.
  logic [WIDTH-1:0] mq [NUM_Q][$];
  int               rr_m;
  bit               lock_m;
  int               lock_qid_m;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    wr_valid_i = 1'b0;
    wr_qid_i   = '0;
    wr_data_i  = '0;
    rd_ready_i = 1'b0;
    urgent_i   = '0;
    flush_i    = '0;
  endtask

  task automatic model_reset();
    for (int q = 0; q < NUM_Q; q++) mq[q].delete();
    rr_m       = 0;
    lock_m     = 1'b0;
    lock_qid_m = 0;
  endtask

  function automatic void model_grant(output bit v, output int qid);
    bit [NUM_Q-1:0] e;
    bit [NUM_Q-1:0] u;
    v   = 1'b0;
    qid = 0;
    if (lock_m) begin
      v   = 1'b1;
      qid = lock_qid_m;
      return;
    end
    for (int q = 0; q < NUM_Q; q++) e[q] = (mq[q].size() != 0);
    u = e & urgent_i;
    if (u != 0) e = u;
    for (int i = 0; i < NUM_Q; i++) begin
      if (e[(rr_m + i) % NUM_Q]) begin
        v   = 1'b1;
        qid = (rr_m + i) % NUM_Q;
        return;
      end
    end
  endfunction

  task automatic check_all();
    bit                  v;
    int                  g;
    logic [NUM_Q-1:0]    ee, ef, ea;
    logic [NUM_Q*CW-1:0] ec;
    model_grant(v, g);
    chk("rd_valid", rd_valid_o, v);
    if (v) begin
      chk("rd_qid", rd_qid_o, g);
      chk("rd_data", rd_data_o, mq[g][0]);
    end else begin
      chk("rd_data_idle", rd_data_o, 0);
    end
    chk("wr_ready", wr_ready_o, (mq[wr_qid_i].size() < DEPTH) && !flush_i[wr_qid_i]);
    for (int q = 0; q < NUM_Q; q++) begin
      ee[q]            = (mq[q].size() == 0);
      ef[q]            = (mq[q].size() == DEPTH);
      ea[q]            = (mq[q].size() >= AFULL_TH);
      ec[q*CW +: CW]   = CW'(mq[q].size());
    end
    chk("empty", empty_o, ee);
    chk("full", full_o, ef);
    chk("afull", afull_o, ea);
    chk("count", count_o, ec);
  endtask

  // Apply the spec rules for one clock edge using the current inputs.
  task automatic model_step();
    bit v;
    int g;
    bit push_ok;
    bit pop_ok;
    model_grant(v, g);
    push_ok = wr_valid_i && (mq[wr_qid_i].size() < DEPTH) && !flush_i[wr_qid_i];
    pop_ok  = v && rd_ready_i && !flush_i[g];
    if (pop_ok) begin
      void'(mq[g].pop_front());
      rr_m   = (g + 1) % NUM_Q;
      lock_m = 1'b0;
    end else if (v && !rd_ready_i && !flush_i[g]) begin
      lock_m     = 1'b1;
      lock_qid_m = g;
    end else begin
      lock_m = 1'b0;
    end
    if (push_ok) mq[wr_qid_i].push_back(wr_data_i);
    for (int q = 0; q < NUM_Q; q++) if (flush_i[q]) mq[q].delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    #1;
    check_all();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("reset_rd_valid", rd_valid_o, 0);
    chk("reset_rd_qid", rd_qid_o, 0);
    chk("reset_empty", empty_o, 4'b1111);
    chk("reset_wr_ready", wr_ready_o, 1);
  endtask

  task automatic push_word(input int q, input logic [WIDTH-1:0] d, input bit rdy);
    wr_valid_i = 1'b1;
    wr_qid_i   = QW'(q);
    wr_data_i  = d;
    rd_ready_i = rdy;
    cycle();
    wr_valid_i = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               wv;
    int               wq;
    logic [WIDTH-1:0] wd;
    bit               rdy;
    logic [NUM_Q-1:0] urg;
    bit               ev;
    int               eq;
    logic [WIDTH-1:0] ed;
    logic [NUM_Q-1:0] eempty;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit wv, int wq, logic [WIDTH-1:0] wd, bit rdy, logic [NUM_Q-1:0] urg,
                              bit ev, int eq, logic [WIDTH-1:0] ed, logic [NUM_Q-1:0] eempty);
    vec_t v;
    v.wv = wv; v.wq = wq; v.wd = wd; v.rdy = rdy; v.urg = urg;
    v.ev = ev; v.eq = eq; v.ed = ed; v.eempty = eempty;
    return v;
  endfunction

  initial begin
    logic [WIDTH-1:0] rnd;
    rst_i = 1'b1;
    set_idle();

    // Rows: push/pop stimulus, then the outputs expected before that edge.
    tbl.push_back(mk(0, 0, 'h00, 0, 4'h0, 0, 0, 'h00, 4'hF));
    tbl.push_back(mk(1, 2, 'hA5, 0, 4'h0, 0, 0, 'h00, 4'hF));
    tbl.push_back(mk(0, 0, 'h00, 0, 4'h0, 1, 2, 'hA5, 4'hB));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h0, 1, 2, 'hA5, 4'hB));
    tbl.push_back(mk(0, 0, 'h00, 0, 4'h0, 0, 0, 'h00, 4'hF));
    tbl.push_back(mk(1, 0, 'h10, 0, 4'h0, 0, 0, 'h00, 4'hF));
    tbl.push_back(mk(1, 1, 'h11, 0, 4'h0, 1, 0, 'h10, 4'hE));
    tbl.push_back(mk(1, 2, 'h12, 0, 4'h0, 1, 0, 'h10, 4'hC));
    tbl.push_back(mk(1, 3, 'h13, 0, 4'h0, 1, 0, 'h10, 4'h8));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h0, 1, 0, 'h10, 4'h0));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h0, 1, 1, 'h11, 4'h1));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h0, 1, 2, 'h12, 4'h3));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h0, 1, 3, 'h13, 4'h7));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h0, 0, 0, 'h00, 4'hF));
    tbl.push_back(mk(1, 0, 'h20, 0, 4'h0, 0, 0, 'h00, 4'hF));
    tbl.push_back(mk(1, 1, 'h21, 0, 4'h0, 1, 0, 'h20, 4'hE));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h0, 1, 0, 'h20, 4'hC));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h0, 1, 1, 'h21, 4'hD));
    tbl.push_back(mk(0, 0, 'h00, 0, 4'h0, 0, 0, 'h00, 4'hF));
    tbl.push_back(mk(1, 3, 'h33, 0, 4'h8, 0, 0, 'h00, 4'hF));
    tbl.push_back(mk(1, 0, 'h30, 0, 4'h8, 1, 3, 'h33, 4'h7));
    tbl.push_back(mk(0, 0, 'h00, 0, 4'h9, 1, 3, 'h33, 4'h6));
    tbl.push_back(mk(0, 0, 'h00, 0, 4'h1, 1, 3, 'h33, 4'h6));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h1, 1, 3, 'h33, 4'h6));
    tbl.push_back(mk(0, 0, 'h00, 1, 4'h0, 1, 0, 'h30, 4'hE));
    tbl.push_back(mk(0, 0, 'h00, 0, 4'h0, 0, 0, 'h00, 4'hF));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      wr_valid_i = tbl[i].wv;
      wr_qid_i   = QW'(tbl[i].wq);
      wr_data_i  = tbl[i].wd;
      rd_ready_i = tbl[i].rdy;
      urgent_i   = tbl[i].urg;
      #1;
      chk($sformatf("tbl%0d_rd_valid", i), rd_valid_o, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_rd_qid", i), rd_qid_o, tbl[i].eq);
      chk($sformatf("tbl%0d_rd_data", i), rd_data_o, tbl[i].ed);
      chk($sformatf("tbl%0d_empty", i), empty_o, tbl[i].eempty);
      model_step();
      @(posedge clk_i);
      #1;
    end
    set_idle();

    // Fill q1 to full, watching almost-full, then push+pop on the full queue.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      push_word(1, rnd, 1'b0);
      chk("fill_count_q1", count_slice(count_o, 1), i + 1);
      chk("fill_afull_q1", afull_o[1], (i + 1) >= AFULL_TH);
    end
    wr_valid_i = 1'b1;
    wr_qid_i   = 2'd1;
    wr_data_i  = 'h5A5A;
    #1;
    chk("full_q1", full_o[1], 1);
    chk("wr_ready_full_q1", wr_ready_o, 0);
    rd_ready_i = 1'b1;
    cycle();
    chk("full_pushpop_count_q1", count_slice(count_o, 1), 15);
    chk("full_pushpop_full_q1", full_o[1], 0);
    set_idle();
    cycle();

    // Flush a locked queue while the consumer accepts it.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(2, WIDTH'(32'h200 + i), 1'b0);
    push_word(3, 'h300, 1'b0);
    #1;
    chk("flush_pre_qid", rd_qid_o, 2);
    flush_i    = 4'b0100;
    rd_ready_i = 1'b1;
    cycle();
    flush_i    = '0;
    rd_ready_i = 1'b0;
    #1;
    chk("flush_count_q2", count_slice(count_o, 2), 0);
    chk("flush_empty_q2", empty_o[2], 1);
    chk("flush_rd_valid", rd_valid_o, 1);
    chk("flush_rd_qid", rd_qid_o, 3);
    chk("flush_rd_data", rd_data_o, 'h300);
    cycle();

    // Asynchronous reset in the middle of traffic.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(i % NUM_Q, WIDTH'($urandom), 1'($urandom_range(0, 1)));
    set_idle();
    #2;
    rst_i = 1'b1;
    #1;
    chk("areset_rd_valid", rd_valid_o, 0);
    chk("areset_rd_qid", rd_qid_o, 0);
    chk("areset_rd_data", rd_data_o, 0);
    chk("areset_empty", empty_o, 4'b1111);
    chk("areset_full", full_o, 0);
    chk("areset_afull", afull_o, 0);
    chk("areset_count", count_o, 0);
    chk("areset_wr_ready", wr_ready_o, 1);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    push_word(0, 'hBEEF, 1'b0);
    #1;
    chk("areset_base_data", rd_data_o, 'hBEEF);
    chk("areset_base_count", count_slice(count_o, 0), 1);
    cycle();

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      wr_valid_i = ($urandom_range(0, 3) != 0);
      wr_qid_i   = QW'($urandom_range(0, NUM_Q - 1));
      wr_data_i  = {$urandom, $urandom, $urandom};
      rd_ready_i = ($urandom_range(0, 2) == 0);
      urgent_i   = ($urandom_range(0, 3) == 0) ? NUM_Q'($urandom) : '0;
      flush_i    = ($urandom_range(0, 24) == 0) ? NUM_Q'(1 << $urandom_range(0, NUM_Q - 1)) : '0;
      cycle();
    end
    set_idle();
    rd_ready_i = 1'b1;
    repeat (80) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
